add64_seq: RTL

ADD64_SEQ -- requirements
Module: add64_seq

---
 rtl/add64_seq_pkg.sv | 13 +
 rtl/RCA_32bit.sv | 24 ++
 rtl/add64_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/add64_seq_pkg.sv
// Shared definitions for the half-width sequential adder: FSM states and default widths.
package add64_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } add_state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_HALF  = 32;

endpackage

// File: rtl/RCA_32bit.sv
// Ripple-carry adder slice; the carry chain is built bit by bit from full adders.
module RCA_32bit #(
  parameter int N = 32
) (
  output logic [N-1:0] sum,
  output logic         cout,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin
);

  logic [N:0] w_c;

  assign w_c[0] = cin;

  // One full adder per bit, carry rippling from bit 0 upward
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[N];

endmodule

// File: rtl/add64_seq.sv
// Sequential WIDTH-bit adder that reuses one HALF-bit ripple slice over two cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; operands captured when start is seen
// S_LO   | low half through the slice, carry stored for the high half
// S_HI   | high half through the slice, cout/ovf written, done raised
module add64_seq
  import add64_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HALF  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  add_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [HALF-1:0]  w_slice_a;
  logic [HALF-1:0]  w_slice_b;
  logic             w_slice_cin;
  logic [HALF-1:0]  w_slice_sum;
  logic             w_slice_cout;
  logic             w_sel_hi;

  // The slice sees the high operand halves and stored carry only in S_HI
  assign w_sel_hi    = (r_state == S_HI);
  assign w_slice_a   = w_sel_hi ? r_a[WIDTH-1:HALF] : r_a[HALF-1:0];
  assign w_slice_b   = w_sel_hi ? r_b[WIDTH-1:HALF] : r_b[HALF-1:0];
  assign w_slice_cin = w_sel_hi ? r_carry : r_cin;

  RCA_32bit #(
    .N (HALF)
  ) u_slice (
    .sum  (w_slice_sum),
    .cout (w_slice_cout),
    .a    (w_slice_a),
    .b    (w_slice_b),
    .cin  (w_slice_cin)
  );

  // FSM, operand capture and registered results in one block
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_cin   <= cin;
            r_busy  <= 1'b1;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          r_sum[HALF-1:0] <= w_slice_sum;
          r_carry         <= w_slice_cout;
          r_state         <= S_HI;
        end
        S_HI: begin
          r_sum[WIDTH-1:HALF] <= w_slice_sum;
          r_cout              <= w_slice_cout;
          // Signed overflow: like-signed operands producing a result of the other sign
          r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_slice_sum[HALF-1] != r_a[WIDTH-1]);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
